// File: rtl/urna_tally_arbiter.sv
// urna_tally_arbiter
//   Round-robin arbiter letting N_BOOTHS voting booths share the single
//   increment port of the tally bank (C1..C4 plus Nulo). Each granted vote
//   goes through IDLE -> ISSUE -> ACK, so one vote is accepted every three
//   cycles at best. A Finish pulse snapshots the booths requesting at that
//   moment, drains them, and then locks the block in CLOSED until reset.
//
// Optional build macro: URNA_ARB_STATS_EN enables the saturating
//   accepted-vote counter on o_vote_total (tied to 0 otherwise).
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_req        per-booth vote request, held until acknowledged
//   i_vote_code  flattened codes, booth i at [i*CODE_W +: CODE_W]
//   i_finish     election-close pulse
//   i_inc_ready  tally bank accepts an increment this cycle
//   o_ack        one-cycle acknowledge to the served booth
//   o_inc_valid  increment request to the tally bank
//   o_inc_sel    tally index 0..3 = C1..C4, NULO_CODE = Nulo
//   o_busy       high in ISSUE or ACK
//   o_closed     election closed
//   o_vote_total accepted-vote count
module urna_tally_arbiter #(
  parameter int N_BOOTHS  = 4,
  parameter int CODE_W    = 3,
  parameter int NULO_CODE = 4,
  parameter int STAT_W    = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [N_BOOTHS-1:0]        i_req,
  input  logic [N_BOOTHS*CODE_W-1:0] i_vote_code,
  input  logic                       i_finish,
  input  logic                       i_inc_ready,
  output logic [N_BOOTHS-1:0]        o_ack,
  output logic                       o_inc_valid,
  output logic [2:0]                 o_inc_sel,
  output logic                       o_busy,
  output logic                       o_closed,
  output logic [STAT_W-1:0]          o_vote_total
);

  localparam int PTR_W = $clog2(N_BOOTHS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_CLOSED} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_grant;
  logic                r_closing;
  logic [N_BOOTHS-1:0] r_pend;
  logic [N_BOOTHS-1:0] r_ack;
  logic                r_inc_valid;
  logic [2:0]          r_inc_sel;

  logic [N_BOOTHS-1:0] w_elig;
  logic                w_found;
  logic [PTR_W-1:0]    w_gidx;
  int                  w_idx;
  logic                w_xfer;

  // Codes above C4 (blank / invalid) all collapse onto the Nulo tally.
  function automatic logic [2:0] map_code(input logic [CODE_W-1:0] code);
    if (int'(code) <= 3) return 3'(code);
    else                 return 3'(NULO_CODE);
  endfunction

  // Once closing, only booths captured in the Finish snapshot may be served.
  always_comb begin
    w_elig  = r_closing ? (i_req & r_pend) : i_req;
    w_found = 1'b0;
    w_gidx  = r_ptr;
    w_idx   = 0;
    for (int k = 0; k < N_BOOTHS; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N_BOOTHS) w_idx = w_idx - N_BOOTHS;
      if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_idx[PTR_W-1:0];
      end
    end
  end

  assign w_xfer = r_inc_valid & i_inc_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found)        w_next = S_ISSUE;
        else if (r_closing) w_next = S_CLOSED;
      end
      S_ISSUE:  if (i_inc_ready) w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      S_CLOSED: w_next = S_CLOSED;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_closing   <= 1'b0;
      r_pend      <= '0;
      r_ack       <= '0;
      r_inc_valid <= 1'b0;
      r_inc_sel   <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= '0;
      case (r_state)
        // grant stage: latch winner and its code
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_gidx;
            r_inc_valid <= 1'b1;
            r_inc_sel   <= map_code(i_vote_code[w_gidx*CODE_W +: CODE_W]);
          end
        end
        // issue stage: hold request until the tally bank takes it
        S_ISSUE: begin
          if (w_xfer) begin
            r_inc_valid <= 1'b0;
            r_ack       <= N_BOOTHS'(1) << r_grant;
          end
        end
        // ack stage: advance the round-robin pointer past the served booth
        S_ACK: begin
          r_ptr           <= (int'(r_grant) == N_BOOTHS - 1) ? '0 : r_grant + 1'b1;
          r_pend[r_grant] <= 1'b0;
        end
        default: ;
      endcase
      // r_ack is one-hot on the served booth only during ACK, so masking it
      // drops a booth whose vote is being acknowledged in the Finish cycle.
      if (i_finish && !r_closing && (r_state != S_CLOSED)) begin
        r_closing <= 1'b1;
        r_pend    <= i_req & ~r_ack;
      end
    end
  end

  assign o_ack       = r_ack;
  assign o_inc_valid = r_inc_valid;
  assign o_inc_sel   = r_inc_sel;
  assign o_busy      = (r_state == S_ISSUE) || (r_state == S_ACK);
  assign o_closed    = (r_state == S_CLOSED);

`ifdef URNA_ARB_STATS_EN
  logic [STAT_W-1:0] r_total;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge i_clock) begin
    if (i_reset)     r_total <= '0;
    else if (w_xfer) r_total <= sat_inc(r_total);
  end

  assign o_vote_total = r_total;
`else
  assign o_vote_total = '0;
`endif

endmodule

// File: doc/urna_tally_arbiter.md
Name: urna_tally_arbiter

Overview:
- Round-robin arbiter that lets N voting booths share one tally update port of the electronic ballot box (candidates C1..C4 plus Nulo).
- Each booth submits a completed vote code through a Req/Ack handshake. The arbiter serialises the codes into single increment requests toward the tally bank.
- A Finish pulse closes the election. Votes already pending are drained, then the block locks in CLOSED.

Parameters:
- N_BOOTHS, 4, number of requesting booths (2..8).
- CODE_W, 3, vote code width per booth.
- NULO_CODE, 4, code forwarded for blank/invalid votes. Codes 0..3 select C1..C4.
- STAT_W, 8, width of optional accepted-vote counter.

Ports:
- Clock  in  1  single system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  N_BOOTHS  per-booth vote request; held high until Ack.
- VoteCode  in  N_BOOTHS*CODE_W  flattened codes; booth i occupies bits [i*CODE_W +: CODE_W]; must be stable while Req[i]=1.
- Finish  in  1  election-close pulse.
- IncReady  in  1  tally bank can accept an increment this cycle.
- Ack  out  N_BOOTHS  one-cycle acknowledge to the granted booth.
- IncValid  out  1  increment request to tally bank.
- IncSel  out  3  tally index: 0..3 = C1..C4, 4 = Nulo.
- Busy  out  1  high in any state other than IDLE/CLOSED.
- Closed  out  1  election closed.
- VoteTotal  out  STAT_W  accepted-vote count (optional feature).

Behaviour:
- Reset: state=IDLE, pointer=0, Closing=0, PendMask=0. Ack=0, IncValid=0, IncSel=0, Busy=0, Closed=0, VoteTotal=0. Reset wins over every other input in every state, including mid-ISSUE. An IncValid in flight is dropped and no Ack is issued.
- Eligible set: Req when Closing=0; Req & PendMask when Closing=1.
- IDLE:
  - If the eligible set is non-empty, grant the first set bit scanning from pointer upward with wrap (pointer, pointer+1, ... N-1, 0, ...).
  - Latch grant index and its VoteCode. Go to ISSUE.
  - If Closing=1 and the eligible set is empty, go to CLOSED.
- ISSUE:
  - IncValid=1; IncSel = latched code if code<=3, else NULO_CODE.
  - Hold until the cycle with IncValid & IncReady (transfer edge), then go to ACK.
  - IncValid/IncSel are registered outputs and stay stable while waiting.
- ACK:
  - Ack[grant]=1 for exactly one cycle. pointer = grant+1 (wraps N_BOOTHS-1 -> 0). Clear PendMask[grant].
  - Go to IDLE. A booth is never re-granted before its Ack cycle has passed.
- CLOSED: Closed=1. Ack/IncValid held 0; Req and Finish ignored. Exit only via Reset.
- Finish (any state except CLOSED, first occurrence): Closing=1 and PendMask = Req sampled that cycle.
  - If that cycle is ACK, the acknowledged booth is excluded from PendMask.
  - Later Finish pulses are ignored.
  - Req asserted after the Finish cycle is never served.
- Latency: an uncontended vote with IncReady=1 gives IDLE grant at cycle 0, IncValid at cycle 1, Ack at cycle 2, next grant possible at cycle 3. Throughput is 1 vote per 3 cycles.
- Req dropped while waiting in ISSUE is a protocol violation. The latched vote is still completed and acknowledged.
- Busy = (state==ISSUE || state==ACK).

Optional Feature:
- Macro URNA_ARB_STATS_EN.
- Defined: VoteTotal increments by 1 on each ISSUE transfer edge and saturates at 2^STAT_W-1. It is cleared only by Reset.
- Undefined: no counter logic; VoteTotal is tied to 0.

Test Plan:
- Reset, booth0 Req with code 2, IncReady=1 -> IncValid=1, IncSel=2 one cycle later; Ack=4'b0001 the next cycle; VoteTotal=1 (with URNA_ARB_STATS_EN).
- Booths 0,1,3 Req simultaneously, pointer=0 -> grant order 0,1,3; then booth0 re-requests with booth3 -> booth0 granted before booth3? No: pointer=0 after booth3's Ack, so the order is 0 then 3 only if both pending; verify pointer wrap 3->0.
- Booth2 code 7, IncReady held 0 for 5 cycles -> IncValid and IncSel=4 stable for 5 cycles; Ack[2] only after IncReady=1.
- Booths 1,2 pending, Finish pulsed, booth0 Req one cycle later -> booths 1 and 2 served, booth0 never Ack'd, Closed=1 after the last Ack.
- Reset asserted during ISSUE with IncReady=0 -> next cycle IncValid=0, Ack=0, state IDLE, pointer=0, Closed=0.
- In CLOSED, Req=all ones plus Finish -> no IncValid, no Ack for 20 cycles; Closed stays 1.
